// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the MIPS core.
// Selects next PC (exception > jump > branch > PC+4) and runs a req/ack fetch handshake.
module pc_sequencer #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             exc,
    output logic             fetch_req,
    output logic [WIDTH-1:0] fetch_addr,
    input  logic             fetch_ack,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc4_out,
    output logic             inst_valid,
    output logic             misalign_err
);

    typedef enum logic [1:0] {StBoot, StFetch, StIssue, StError} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             exc_pend_q, exc_pend_d;
    logic [WIDTH-1:0] redirect_target;
    logic             redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            exc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            exc_pend_q <= exc_pend_d;
        end
    end

    assign pc4_out         = pc_q + WIDTH'(4);
    assign redirect        = jmp | br_taken;
    assign redirect_target = jmp ? jmp_target : br_target;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        exc_pend_d = exc_pend_q;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
                if (exc) begin
                    pc_d = EXC_VECTOR;
                end
            end
            StFetch: begin
                // Address must stay stable until ack; an exception is deferred until then.
                if (fetch_ack) begin
                    if (exc || exc_pend_q) begin
                        pc_d       = EXC_VECTOR;
                        exc_pend_d = 1'b0;
                    end else begin
                        state_d = StIssue;
                    end
                end else if (exc) begin
                    exc_pend_d = 1'b1;
                end
            end
            StIssue: begin
                if (exc) begin
                    pc_d    = EXC_VECTOR;
                    state_d = StFetch;
                end else if (!stall) begin
                    if (redirect) begin
                        pc_d    = redirect_target;
                        state_d = (redirect_target[1:0] != 2'b00) ? StError : StFetch;
                    end else begin
                        pc_d    = pc4_out;
                        state_d = StFetch;
                    end
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    assign pc_out       = pc_q;
    assign fetch_addr   = pc_q;
    assign fetch_req    = (state_q == StFetch);
    assign inst_valid   = (state_q == StIssue);
    assign misalign_err = (state_q == StError);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, redirects, stall, exceptions,
// misalignment trap and PC wrap-around.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic        inst_valid;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .exc          (exc),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_ack    (fetch_ack),
        .pc_out       (pc_out),
        .pc4_out      (pc4_out),
        .inst_valid   (inst_valid),
        .misalign_err (misalign_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: wait (delay-1) idle cycles, then ack for one cycle; ends in ISSUE.
    task automatic do_fetch(input int delay);
        for (int i = 1; i < delay; i++) step();
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        jmp = 1'b0; jmp_target = '0; exc = 1'b0; fetch_ack = 1'b0;

        // T1: reset, then sequential fetch with 2-cycle ack
        step();
        check("rst_pc", pc_out, 32'h0000_3000);
        check("rst_req", {31'd0, fetch_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_err", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        step();
        check("t1_req", {31'd0, fetch_req}, 32'd1);
        check("t1_addr0", fetch_addr, 32'h0000_3000);
        do_fetch(2);
        check("t1_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_req_issue", {31'd0, fetch_req}, 32'd0);
        check("t1_pc4", pc4_out, 32'h0000_3004);
        step();
        check("t1_addr1", fetch_addr, 32'h0000_3004);
        check("t1_valid_drop", {31'd0, inst_valid}, 32'd0);
        do_fetch(1);
        step();
        check("t1_addr2", fetch_addr, 32'h0000_3008);

        // T2: jmp beats br, then br alone
        do_fetch(1);
        br_taken = 1'b1; br_target = 32'h0000_3100;
        jmp = 1'b1; jmp_target = 32'h0000_3200;
        step();
        jmp = 1'b0; br_taken = 1'b0;
        check("t2_jmp_wins", pc_out, 32'h0000_3200);
        check("t2_req", {31'd0, fetch_req}, 32'd1);
        do_fetch(1);
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        check("t2_br", pc_out, 32'h0000_3100);

        // T3: stall in ISSUE at 0x3010, redirect ignored while stalled
        do_fetch(1);
        jmp = 1'b1; jmp_target = 32'h0000_3010;
        step();
        jmp = 1'b0;
        do_fetch(1);
        stall = 1'b1; br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_pc", pc_out, 32'h0000_3010);
            check("t3_stall_valid", {31'd0, inst_valid}, 32'd1);
        end
        stall = 1'b0; br_taken = 1'b0;
        step();
        check("t3_release", pc_out, 32'h0000_3014);

        // T4: exception before ack; ack discarded, refetch at vector
        step();
        exc = 1'b1;
        step();
        exc = 1'b0;
        check("t4_addr_hold", fetch_addr, 32'h0000_3014);
        check("t4_req_hold", {31'd0, fetch_req}, 32'd1);
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        check("t4_discard", {31'd0, inst_valid}, 32'd0);
        check("t4_vec", fetch_addr, 32'h0000_4180);
        check("t4_req_new", {31'd0, fetch_req}, 32'd1);
        do_fetch(1);
        check("t4_valid_vec", {31'd0, inst_valid}, 32'd1);

        // T6: wrap-around from 0xFFFF_FFFC
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        step();
        jmp = 1'b0;
        check("t6_top", pc_out, 32'hFFFF_FFFC);
        check("t6_top_pc4", pc4_out, 32'h0000_0000);
        do_fetch(1);
        step();
        check("t6_wrap", pc_out, 32'h0000_0000);
        check("t6_wrap_pc4", pc4_out, 32'h0000_0004);

        // T5: misaligned jump traps; sticky until reset
        do_fetch(1);
        jmp = 1'b1; jmp_target = 32'h0000_3002;
        step();
        jmp = 1'b0;
        check("t5_err", {31'd0, misalign_err}, 32'd1);
        check("t5_pc", pc_out, 32'h0000_3002);
        check("t5_req", {31'd0, fetch_req}, 32'd0);
        check("t5_valid", {31'd0, inst_valid}, 32'd0);
        exc = 1'b1; fetch_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_sticky", {31'd0, misalign_err}, 32'd1);
        end
        exc = 1'b0; fetch_ack = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t5_refetch_req", {31'd0, fetch_req}, 32'd1);
        reset = 1'b1;
        step();
        check("t5_rst_pc", pc_out, 32'h0000_3000);
        check("t5_rst_err", {31'd0, misalign_err}, 32'd0);
        check("t5_rst_req", {31'd0, fetch_req}, 32'd0);
        reset = 1'b0;

        // Exception wins over stall in ISSUE
        step();
        do_fetch(1);
        stall = 1'b1; exc = 1'b1;
        step();
        stall = 1'b0; exc = 1'b0;
        check("exc_stall_pc", pc_out, 32'h0000_4180);
        check("exc_stall_valid", {31'd0, inst_valid}, 32'd0);
        check("exc_stall_req", {31'd0, fetch_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
